// File: rtl/id_stage_pkg.sv
// Shared decode definitions: opcodes, immediate format select, ID/EX slot layout.
package id_stage_pkg;

    // Slot fields are sized for the widest legal configuration and sliced at the top.
    localparam int IDEX_XLEN = 64;
    localparam int IDEX_RA_W = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [IDEX_XLEN-1:0] pc;
        logic [IDEX_XLEN-1:0] rs1_data;
        logic [IDEX_XLEN-1:0] rs2_data;
        logic [IDEX_XLEN-1:0] imm;
        logic [IDEX_RA_W-1:0] rd_addr;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
        logic                 branch;
        logic                 alu_src_b_sel;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
    } idex_t;

endpackage

// File: rtl/control_unit.sv
// Main control decode from the opcode field.
module control_unit
    import id_stage_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       branch,
    output logic       alu_src_b_sel,
    output imm_type_e  imm_type
);

    // Opcode to control-bit table; unknown opcodes decode to a no-op.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        branch        = 1'b0;
        alu_src_b_sel = 1'b0;
        imm_type      = IMM_NONE;
        case (opcode)
            OP_RTYPE:  reg_write = 1'b1;
            OP_ITYPE:  begin reg_write = 1'b1; alu_src_b_sel = 1'b1; imm_type = IMM_I; end
            OP_LOAD:   begin mem_read = 1'b1; reg_write = 1'b1; alu_src_b_sel = 1'b1; imm_type = IMM_I; end
            OP_STORE:  begin mem_write = 1'b1; alu_src_b_sel = 1'b1; imm_type = IMM_S; end
            OP_BRANCH: begin branch = 1'b1; imm_type = IMM_B; end
            OP_LUI,
            OP_AUIPC:  begin reg_write = 1'b1; alu_src_b_sel = 1'b1; imm_type = IMM_U; end
            OP_JAL:    begin reg_write = 1'b1; branch = 1'b1; imm_type = IMM_J; end
            OP_JALR:   begin reg_write = 1'b1; branch = 1'b1; alu_src_b_sel = 1'b1; imm_type = IMM_I; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe_regfile_bypass.sv
// Architectural register array with hardwired x0 and optional write-back bypass.
module regfile_bypass #(
    parameter int XLEN      = 64,
    parameter int NUM_REGS  = 32,
    parameter int RA_W      = $clog2(NUM_REGS),
    parameter int BYPASS_WB = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [RA_W-1:0]           waddr,
    input  logic [XLEN-1:0]           wdata,
    input  logic [1:0][RA_W-1:0]      raddr,
    output logic [1:0][XLEN-1:0]      rdata
);

    logic [XLEN-1:0] regs [NUM_REGS];

    // Write port; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: x0 forces zero ahead of the bypass, bypass ahead of the array.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rdata[p] = (raddr[p] == '0)                                   ? '0    :
                          (BYPASS_WB != 0 && we && waddr == raddr[p])         ? wdata :
                                                                                regs[raddr[p]];
    end

endmodule

// File: rtl/immediate_generator.sv
// Assembles the 32-bit sign-extended immediate for each instruction format.
module immediate_generator
    import id_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    // Format-specific bit scatter/gather.
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: decode + operand read into a registered ID/EX slot with
// load-use bubble insertion, flush, and a stall-cycle counter.
module id_stage_pipe
    import id_stage_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NUM_REGS  = 32,
    parameter int RA_W      = $clog2(NUM_REGS),
    parameter int BYPASS_WB = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [RA_W-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic              ex_alu_src_b_sel,
    output logic [2:0]        ex_alu_funct3,
    output logic [6:0]        ex_alu_funct7,
    output logic [31:0]       stall_cnt
);

    logic [RA_W-1:0]       rs1, rs2;
    logic [1:0][XLEN-1:0]  rdata;
    logic                  c_mr, c_mw, c_rw, c_br, c_as;
    imm_type_e             imm_sel;
    logic [31:0]           imm32;
    logic [XLEN-1:0]       imm_x;
    idex_t                 dec, slot;
    logic                  load, hazard, accept, rdy_en;

    assign rs1 = RA_W'(if_instr[19:15]);
    assign rs2 = RA_W'(if_instr[24:20]);

    control_unit u_ctrl (
        .opcode        (if_instr[6:0]),
        .mem_read      (c_mr),
        .mem_write     (c_mw),
        .reg_write     (c_rw),
        .branch        (c_br),
        .alu_src_b_sel (c_as),
        .imm_type      (imm_sel)
    );

    immediate_generator u_imm (
        .instr    (if_instr),
        .imm_type (imm_sel),
        .imm      (imm32)
    );

    regfile_bypass #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .RA_W      (RA_W),
        .BYPASS_WB (BYPASS_WB)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_reg_write),
        .waddr (wb_rd_addr),
        .wdata (wb_data),
        .raddr ({rs2, rs1}),
        .rdata (rdata)
    );

    assign imm_x = XLEN'($signed(imm32));

    // Pack the decoded payload into the slot layout.
    always_comb begin
        dec               = '0;
        dec.pc            = IDEX_XLEN'(if_pc);
        dec.rs1_data      = IDEX_XLEN'(rdata[0]);
        dec.rs2_data      = IDEX_XLEN'(rdata[1]);
        dec.imm           = IDEX_XLEN'(imm_x);
        dec.rd_addr       = IDEX_RA_W'(RA_W'(if_instr[11:7]));
        dec.mem_read      = c_mr;
        dec.mem_write     = c_mw;
        dec.reg_write     = c_rw;
        dec.branch        = c_br;
        dec.alu_src_b_sel = c_as;
        dec.funct3        = if_instr[14:12];
        dec.funct7        = if_instr[31:25];
    end

    // rdy_en holds id_ready low until the first edge after reset release,
    // so that edge behaves as idle even if fetch is already presenting.
    assign load     = ~ex_valid | ex_ready;
    assign hazard   = if_valid & ex_valid & slot.mem_read &
                      (slot.rd_addr[RA_W-1:0] != '0) &
                      ((slot.rd_addr[RA_W-1:0] == rs1) | (slot.rd_addr[RA_W-1:0] == rs2));
    assign id_ready = rdy_en & (flush | (load & ~hazard));
    assign accept   = if_valid & id_ready & ~flush;

    // Output slot, valid flag and saturating bubble counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot      <= '0;
            ex_valid  <= 1'b0;
            stall_cnt <= '0;
            rdy_en    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (load) begin
                if (accept) begin
                    slot     <= dec;
                    ex_valid <= 1'b1;
                end else begin
                    ex_valid <= 1'b0;
                end
                if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign ex_pc            = slot.pc[XLEN-1:0];
    assign ex_rs1_data      = slot.rs1_data[XLEN-1:0];
    assign ex_rs2_data      = slot.rs2_data[XLEN-1:0];
    assign ex_imm           = slot.imm[XLEN-1:0];
    assign ex_rd_addr       = slot.rd_addr[RA_W-1:0];
    assign ex_mem_read      = slot.mem_read;
    assign ex_mem_write     = slot.mem_write;
    assign ex_reg_write     = slot.reg_write;
    assign ex_branch        = slot.branch;
    assign ex_alu_src_b_sel = slot.alu_src_b_sel;
    assign ex_alu_funct3    = slot.funct3;
    assign ex_alu_funct7    = slot.funct7;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench: two decode stages (bypass on / off) on shared stimulus, scoreboard on the ID/EX slot.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, flush, wb_reg_write, ex_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc, wb_data;
    logic [4:0]  wb_rd_addr;

    logic        a_id_ready, a_ex_valid, a_mr, a_mw, a_rw, a_br, a_as;
    logic [63:0] a_pc, a_rs1, a_rs2, a_imm;
    logic [4:0]  a_rd;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [31:0] a_stall;

    logic        b_id_ready, b_ex_valid, b_mr, b_mw, b_rw, b_br, b_as;
    logic [63:0] b_pc, b_rs1, b_rs2, b_imm;
    logic [4:0]  b_rd;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [31:0] b_stall;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(64), .NUM_REGS(32), .BYPASS_WB(1)) u_a (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(a_id_ready), .flush(flush), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .ex_valid(a_ex_valid), .ex_ready(ex_ready),
        .ex_pc(a_pc), .ex_rs1_data(a_rs1), .ex_rs2_data(a_rs2), .ex_imm(a_imm),
        .ex_rd_addr(a_rd), .ex_mem_read(a_mr), .ex_mem_write(a_mw), .ex_reg_write(a_rw),
        .ex_branch(a_br), .ex_alu_src_b_sel(a_as), .ex_alu_funct3(a_f3),
        .ex_alu_funct7(a_f7), .stall_cnt(a_stall));

    id_stage_pipe #(.XLEN(64), .NUM_REGS(32), .BYPASS_WB(0)) u_b (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(b_id_ready), .flush(flush), .wb_reg_write(wb_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .ex_valid(b_ex_valid), .ex_ready(ex_ready),
        .ex_pc(b_pc), .ex_rs1_data(b_rs1), .ex_rs2_data(b_rs2), .ex_imm(b_imm),
        .ex_rd_addr(b_rd), .ex_mem_read(b_mr), .ex_mem_write(b_mw), .ex_reg_write(b_rw),
        .ex_branch(b_br), .ex_alu_src_b_sel(b_as), .ex_alu_funct3(b_f3),
        .ex_alu_funct7(b_f7), .stall_cnt(b_stall));

    typedef struct {
        logic [63:0] pc, rs1, rs1_nb, rs2, imm;
        logic [4:0]  rd;
        logic [4:0]  ctl;   // {mem_read, mem_write, reg_write, branch, alu_src_b_sel}
        logic [2:0]  f3;
        logic [6:0]  f7;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] pc, rs1, rs1_nb, rs2, imm, input logic [4:0] rd,
                        input logic [4:0] ctl, input logic [2:0] f3, input logic [6:0] f7);
        exp_t e;
        e.pc = pc; e.rs1 = rs1; e.rs1_nb = rs1_nb; e.rs2 = rs2; e.imm = imm;
        e.rd = rd; e.ctl = ctl; e.f3 = f3; e.f7 = f7;
        q.push_back(e);
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd, rs1, rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [63:0] d);
        wb_reg_write = en; wb_rd_addr = rd; wb_data = d;
    endtask

    task automatic issue(input logic v, input logic [31:0] ins, input logic [63:0] pc);
        if_valid = v; if_instr = ins; if_pc = pc;
    endtask

    // Monitor: every handshake on the bypass instance pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && a_ex_valid === 1'b1 && ex_ready === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_output: got pc %h want none", a_pc);
                end else begin
                    e = q.pop_front();
                    chk("pc", a_pc, e.pc);
                    chk("rs1_bypass", a_rs1, e.rs1);
                    chk("rs2", a_rs2, e.rs2);
                    chk("imm", a_imm, e.imm);
                    chk("rd", 64'(a_rd), 64'(e.rd));
                    chk("ctl", 64'({a_mr, a_mw, a_rw, a_br, a_as}), 64'(e.ctl));
                    chk("funct3", 64'(a_f3), 64'(e.f3));
                    chk("funct7", 64'(a_f7), 64'(e.f7));
                    chk("nb_valid", 64'(b_ex_valid), 64'd1);
                    chk("nb_pc", b_pc, e.pc);
                    chk("rs1_nobypass", b_rs1, e.rs1_nb);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        wb(0, 0, 0); issue(0, 0, 0);
        repeat (2) tick();
        // In reset: everything zero, not ready.
        chk("rst_ex_valid", 64'(a_ex_valid), 0);
        chk("rst_id_ready", 64'(a_id_ready), 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_stall", 64'(a_stall), 0);
        // Release while fetch is presenting: first edge must be idle.
        issue(1, r_add(5'd1, 5'd2, 5'd3), 64'h40);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_id_ready_pre", 64'(a_id_ready), 0);
        @(negedge clk);
        chk("rel_ex_valid", 64'(a_ex_valid), 0);
        chk("rel_id_ready", 64'(a_id_ready), 1);
        issue(0, 0, 0);
        tick();

        // Preload registers.
        wb(1, 5'd1, 64'h1000); tick();
        wb(1, 5'd2, 64'h2000); tick();
        wb(1, 5'd5, 64'h1234); tick();
        wb(1, 5'd7, 64'h55);   tick();

        // add x6,x5,x0
        wb(0, 0, 0);
        issue(1, r_add(5'd6, 5'd5, 5'd0), 64'h100);
        push(64'h100, 64'h1234, 64'h1234, 0, 0, 5'd6, 5'b00100, 3'd0, 7'd0);
        tick();
        // Same-cycle WB of x7 with a read of x7.
        wb(1, 5'd7, 64'hAA);
        issue(1, r_add(5'd11, 5'd7, 5'd0), 64'h104);
        push(64'h104, 64'hAA, 64'h55, 0, 0, 5'd11, 5'b00100, 3'd0, 7'd0);
        tick();
        wb(0, 0, 0);
        issue(1, r_add(5'd12, 5'd7, 5'd0), 64'h108);
        push(64'h108, 64'hAA, 64'hAA, 0, 0, 5'd12, 5'b00100, 3'd0, 7'd0);
        tick();
        // addi x10,x0,-5
        issue(1, {12'hFFB, 5'd0, 3'b000, 5'd10, 7'b0010011}, 64'h10C);
        push(64'h10C, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFB, 5'd10, 5'b00101, 3'd0, 7'h7F);
        tick();
        // sw x2,8(x1)
        issue(1, {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011}, 64'h110);
        push(64'h110, 64'h1000, 64'h1000, 64'h2000, 64'd8, 5'd8, 5'b01001, 3'd2, 7'd0);
        tick();
        issue(0, 0, 0);
        tick();

        // Load-use: ld x8,0(x1) then add x9,x8,x2.
        issue(1, {12'd0, 5'd1, 3'b011, 5'd8, 7'b0000011}, 64'h200);
        push(64'h200, 64'h1000, 64'h1000, 0, 0, 5'd8, 5'b10101, 3'd3, 7'd0);
        tick();
        issue(1, r_add(5'd9, 5'd8, 5'd2), 64'h204);
        push(64'h204, 64'h77, 64'h0, 64'h2000, 0, 5'd9, 5'b00100, 3'd0, 7'd0);
        @(negedge clk);
        chk("hz_id_ready", 64'(a_id_ready), 0);
        tick();
        wb(1, 5'd8, 64'h77);
        @(negedge clk);
        chk("bubble_ex_valid", 64'(a_ex_valid), 0);
        chk("bubble_stall_cnt", 64'(a_stall), 1);
        chk("bubble_id_ready", 64'(a_id_ready), 1);
        tick();
        wb(0, 0, 0); issue(0, 0, 0);
        tick();

        // Back-pressure for 3 cycles.
        ex_ready = 1'b0;
        issue(1, r_add(5'd13, 5'd5, 5'd1), 64'h300);
        push(64'h300, 64'h1234, 64'h1234, 64'h1000, 0, 5'd13, 5'b00100, 3'd0, 7'd0);
        tick();
        issue(1, r_add(5'd14, 5'd1, 5'd2), 64'h304);
        push(64'h304, 64'h1000, 64'h1000, 64'h2000, 0, 5'd14, 5'b00100, 3'd0, 7'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_id_ready", 64'(a_id_ready), 0);
            chk("bp_pc_stable", a_pc, 64'h300);
            chk("bp_rs1_stable", a_rs1, 64'h1234);
            tick();
        end
        ex_ready = 1'b1;
        tick();
        issue(0, 0, 0);
        tick();

        // Flush with a hazard pending.
        issue(1, {12'd0, 5'd2, 5'd3, 5'd15, 7'b0000011}, 64'h400);
        tick();
        ex_ready = 1'b0; flush = 1'b1;
        issue(1, r_add(5'd16, 5'd15, 5'd0), 64'h404);
        @(negedge clk);
        chk("fl_id_ready", 64'(a_id_ready), 1);
        tick();
        flush = 1'b0; ex_ready = 1'b1; issue(0, 0, 0);
        @(negedge clk);
        chk("fl_ex_valid", 64'(a_ex_valid), 0);
        chk("fl_stall_cnt", 64'(a_stall), 1);
        tick();

        // Writes to x0 are ignored, including on the bypass path.
        wb(1, 5'd0, 64'hFF); tick();
        issue(1, r_add(5'd17, 5'd0, 5'd0), 64'h500);
        push(64'h500, 0, 0, 0, 0, 5'd17, 5'b00100, 3'd0, 7'd0);
        tick();
        wb(0, 0, 0); issue(0, 0, 0);
        tick(); tick();

        // Mid-stream asynchronous reset with a held slot.
        ex_ready = 1'b0;
        issue(1, r_add(5'd18, 5'd5, 5'd0), 64'h580);
        tick();
        issue(0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("mrst_ex_valid", 64'(a_ex_valid), 0);
        chk("mrst_pc", a_pc, 0);
        chk("mrst_rs1", a_rs1, 0);
        chk("mrst_stall", 64'(a_stall), 0);
        chk("mrst_id_ready", 64'(a_id_ready), 0);
        ex_ready = 1'b1;
        tick();
        issue(1, r_add(5'd19, 5'd5, 5'd0), 64'h600);
        push(64'h600, 0, 0, 0, 0, 5'd19, 5'b00100, 3'd0, 7'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrel_id_ready_pre", 64'(a_id_ready), 0);
        @(negedge clk);
        chk("mrel_ex_valid", 64'(a_ex_valid), 0);
        tick();
        issue(0, 0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
